// File: rtl/shift_sequencer.sv
// Multi-cycle barrel-free shifter: captures an operand and walks it one bit per
// clock through LSL, LSR or ASR, then signals completion with a one-cycle pulse.
module shift_sequencer (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        start,
   input  logic [15:0] in,
   input  logic [1:0]  shift,
   input  logic [3:0]  amount,
   output logic        busy,
   output logic        done,
   output logic [15:0] sout
);

   localparam int unsigned DATA_W = 16;
   localparam int unsigned CNT_W  = 4;
   localparam int unsigned OP_W   = 2;

   localparam logic [OP_W-1:0] OP_PASS = 2'b00;
   localparam logic [OP_W-1:0] OP_LSL  = 2'b01;
   localparam logic [OP_W-1:0] OP_LSR  = 2'b10;
   localparam logic [OP_W-1:0] OP_ASR  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   sout_q, sout_d;
   logic [OP_W-1:0]     op_q, op_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;

   // One single-bit step of the captured operation
   function automatic logic [DATA_W-1:0] step_f(input logic [OP_W-1:0] op,
                                                input logic [DATA_W-1:0] v);
      logic [DATA_W-1:0] r;
      r = v;
      case (op)
         OP_LSL:  r = {v[DATA_W-2:0], 1'b0};
         OP_LSR:  r = {1'b0, v[DATA_W-1:1]};
         OP_ASR:  r = {v[DATA_W-1], v[DATA_W-1:1]};
         default: r = v;
      endcase
      return r;
   endfunction

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a pass op or zero amount skips SHIFT entirely
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if ((shift == OP_PASS) || (amount == CNT_W'(0))) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_SHIFT;
               end
            end
         end
         ST_SHIFT: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Output decode from the next state so busy/done come straight from flops
   always_comb begin
      busy_d = 1'b0;
      done_d = 1'b0;
      busy_d = (state_d == ST_SHIFT);
      done_d = (state_d == ST_DONE);
   end

   // Datapath next values: capture on accept, step and count down in SHIFT
   always_comb begin
      sout_d = sout_q;
      op_d   = op_q;
      cnt_d  = cnt_q;
      if ((state_q == ST_IDLE) && start) begin
         sout_d = in;
         op_d   = shift;
         cnt_d  = amount;
      end else if (state_q == ST_SHIFT) begin
         sout_d = step_f(op_q, sout_q);
         cnt_d  = cnt_q - CNT_W'(1);
      end
   end

   // Datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sout_q <= '0;
         op_q   <= OP_PASS;
         cnt_q  <= '0;
      end else begin
         sout_q <= sout_d;
         op_q   <= op_d;
         cnt_q  <= cnt_d;
      end
   end

   // Status registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         busy_q <= busy_d;
         done_q <= done_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sout = sout_q;

endmodule
